// File: rtl/sp_bram_arb.sv
// Two-port round-robin arbiter in front of one single-port BRAM. Optional zeroing sweep: SP_BRAM_ARB_INIT_EN.
// Latency: grant is combinational; the response follows 1 cycle after the grant.
// Backpressure: requests are held off via pN_req_ready; responses cannot be stalled.
module sp_bram_arb #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_SETS   = 1024,
   localparam int AW        = $clog2(NUM_SETS)
) (
   input  logic                  clk,
   input  logic                  rst_ni,

   input  logic                  p0_req_valid,
   output logic                  p0_req_ready,
   input  logic                  p0_req_wr,
   input  logic [AW-1:0]         p0_req_addr,
   input  logic [DATA_WIDTH-1:0] p0_req_wdata,
   output logic                  p0_rsp_valid,
   output logic [DATA_WIDTH-1:0] p0_rsp_data,

   input  logic                  p1_req_valid,
   output logic                  p1_req_ready,
   input  logic                  p1_req_wr,
   input  logic [AW-1:0]         p1_req_addr,
   input  logic [DATA_WIDTH-1:0] p1_req_wdata,
   output logic                  p1_rsp_valid,
   output logic [DATA_WIDTH-1:0] p1_rsp_data,

   output logic                  bram_chip_en,
   output logic [AW-1:0]         bram_addr,
   output logic                  bram_wr_en,
   output logic [DATA_WIDTH-1:0] bram_wr_data,
   input  logic [DATA_WIDTH-1:0] bram_rd_data,

   output logic                  init_busy
);

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   typedef struct packed {
      logic                  wr;
      logic [AW-1:0]         addr;
      logic [DATA_WIDTH-1:0] wdata;
   } req_t;

`ifdef SP_BRAM_ARB_INIT_EN
   localparam state_t RST_STATE = ST_INIT;
`else
   localparam state_t RST_STATE = ST_RUN;
`endif

   localparam logic [AW-1:0] LAST_SET = AW'(NUM_SETS - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] init_cnt_q, init_cnt_d;
   logic          ptr_q;
   logic [1:0]    rsp_q;
   logic          run, init_wr, gnt0, gnt1;
   req_t          p0_req, p1_req, bram_req;

   // Everything combinational is gated by rst_ni so nothing leaks out while reset is held.
   assign run     = rst_ni && (state_q == ST_RUN);
   assign init_wr = rst_ni && (state_q == ST_INIT);

   assign gnt0 = run && p0_req_valid && (!p1_req_valid || (ptr_q == 1'b0));
   assign gnt1 = run && p1_req_valid && (!p0_req_valid || (ptr_q == 1'b1));

   assign p0_req_ready = gnt0;
   assign p1_req_ready = gnt1;

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_SET) begin
               state_d = ST_RUN;
            end
         end
         default: ;
      endcase
   end

   assign p0_req = '{wr: p0_req_wr, addr: p0_req_addr, wdata: p0_req_wdata};
   assign p1_req = '{wr: p1_req_wr, addr: p1_req_addr, wdata: p1_req_wdata};

   always_comb begin
      bram_req = p0_req;
      if (gnt1) begin
         bram_req = p1_req;
      end
      if (init_wr) begin
         bram_req = '{wr: 1'b1, addr: init_cnt_q, wdata: '0};
      end
   end

   assign bram_chip_en = gnt0 || gnt1 || init_wr;
   assign bram_wr_en   = bram_chip_en && bram_req.wr;
   assign bram_addr    = bram_req.addr;
   assign bram_wr_data = bram_req.wdata;

   always_ff @(posedge clk) begin
      if (!rst_ni) begin
         state_q    <= RST_STATE;
         init_cnt_q <= '0;
         ptr_q      <= 1'b0;
         rsp_q      <= '0;
      end else begin
         state_q    <= state_d;
         if (state_q == ST_INIT) begin
            init_cnt_q <= init_cnt_d;
         end
         if (gnt0) begin
            ptr_q <= 1'b1;
         end else if (gnt1) begin
            ptr_q <= 1'b0;
         end
         rsp_q <= {gnt1, gnt0};
      end
   end

   // A reset landing in the response cycle suppresses the strobe as well.
   assign p0_rsp_valid = rsp_q[0] && rst_ni;
   assign p1_rsp_valid = rsp_q[1] && rst_ni;
   assign p0_rsp_data  = bram_rd_data;
   assign p1_rsp_data  = bram_rd_data;

`ifdef SP_BRAM_ARB_INIT_EN
   assign init_busy = init_wr;
`else
   assign init_busy = 1'b0;
`endif

endmodule

// File: tb/tb_sp_bram_arb.sv
// Scoreboard bench for sp_bram_arb with a write-first 1-cycle BRAM model and a reference arbiter model.
module tb_sp_bram_arb;
   localparam int DW = 32;
   localparam int NS = 16;
   localparam int AW = 4;
`ifdef SP_BRAM_ARB_INIT_EN
   localparam bit INIT_EN = 1'b1;
`else
   localparam bit INIT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_ni = 1'b0;
   logic          p0_req_valid, p0_req_ready, p0_req_wr, p0_rsp_valid;
   logic [AW-1:0] p0_req_addr;
   logic [DW-1:0] p0_req_wdata, p0_rsp_data;
   logic          p1_req_valid, p1_req_ready, p1_req_wr, p1_rsp_valid;
   logic [AW-1:0] p1_req_addr;
   logic [DW-1:0] p1_req_wdata, p1_rsp_data;
   logic          bram_chip_en, bram_wr_en, init_busy;
   logic [AW-1:0] bram_addr;
   logic [DW-1:0] bram_wr_data, bram_rd_data;

   sp_bram_arb #(.DATA_WIDTH(DW), .NUM_SETS(NS)) dut (
      .clk(clk), .rst_ni(rst_ni),
      .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_wr(p0_req_wr),
      .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
      .p0_rsp_valid(p0_rsp_valid), .p0_rsp_data(p0_rsp_data),
      .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_wr(p1_req_wr),
      .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
      .p1_rsp_valid(p1_rsp_valid), .p1_rsp_data(p1_rsp_data),
      .bram_chip_en(bram_chip_en), .bram_addr(bram_addr), .bram_wr_en(bram_wr_en),
      .bram_wr_data(bram_wr_data), .bram_rd_data(bram_rd_data),
      .init_busy(init_busy)
   );

   always #5 clk = ~clk;

   // Write-first BRAM with one cycle read latency
   logic [DW-1:0] mem [NS];
   always @(posedge clk) begin
      if (bram_chip_en) begin
         if (bram_wr_en) begin
            mem[bram_addr] <= bram_wr_data;
            bram_rd_data   <= bram_wr_data;
         end else begin
            bram_rd_data   <= mem[bram_addr];
         end
      end
   end

   typedef struct {
      int            port;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   int            gnt_log[$];
   logic [DW-1:0] ref_mem [NS];
   int            n_chk = 0;
   int            n_fail = 0;
   int            init_left = 0;
   int            run0 = 0, max_run0 = 0, rsp0_cnt = 0;
   logic          ptr_m = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-cycle monitor: checks responses against the scoreboard and grants against the model.
   always @(negedge clk) begin : mon
      exp_t          e;
      logic          g0, g1, wr;
      logic [AW-1:0] a;
      logic [DW-1:0] wd;
      if (!rst_ni) begin
         check_eq("rst_rdy0", p0_req_ready, 0);
         check_eq("rst_rdy1", p1_req_ready, 0);
         check_eq("rst_ce", bram_chip_en, 0);
         check_eq("rst_rsp0", p0_rsp_valid, 0);
         check_eq("rst_rsp1", p1_rsp_valid, 0);
         check_eq("rst_busy", init_busy, 0);
         sb.delete();
         ptr_m     = 1'b0;
         init_left = INIT_EN ? NS : 0;
         run0      = 0;
      end else begin
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq("rsp_v_own", e.port == 0 ? p0_rsp_valid : p1_rsp_valid, 1);
            check_eq("rsp_v_other", e.port == 0 ? p1_rsp_valid : p0_rsp_valid, 0);
            check_eq("rsp_data", e.port == 0 ? p0_rsp_data : p1_rsp_data, e.data);
         end else begin
            check_eq("idle_rsp0", p0_rsp_valid, 0);
            check_eq("idle_rsp1", p1_rsp_valid, 0);
         end
         run0 = p0_rsp_valid ? run0 + 1 : 0;
         if (run0 > max_run0) max_run0 = run0;
         if (p0_rsp_valid) rsp0_cnt++;

         if (init_left > 0) begin
            check_eq("init_busy", init_busy, 1);
            check_eq("init_rdy0", p0_req_ready, 0);
            check_eq("init_rdy1", p1_req_ready, 0);
            check_eq("init_ce", bram_chip_en, 1);
            check_eq("init_we", bram_wr_en, 1);
            check_eq("init_addr", bram_addr, NS - init_left);
            check_eq("init_wd", bram_wr_data, 0);
            ref_mem[NS - init_left] = '0;
            init_left--;
         end else begin
            check_eq("run_busy", init_busy, 0);
            g0 = p0_req_valid && (!p1_req_valid || ptr_m == 1'b0);
            g1 = p1_req_valid && !g0;
            check_eq("rdy0", p0_req_ready, g0);
            check_eq("rdy1", p1_req_ready, g1);
            check_eq("ce", bram_chip_en, g0 | g1);
            if (p0_req_valid && p0_req_ready) gnt_log.push_back(0);
            if (p1_req_valid && p1_req_ready) gnt_log.push_back(1);
            if (g0 || g1) begin
               wr = g0 ? p0_req_wr : p1_req_wr;
               a  = g0 ? p0_req_addr : p1_req_addr;
               wd = g0 ? p0_req_wdata : p1_req_wdata;
               check_eq("we", bram_wr_en, wr);
               check_eq("addr", bram_addr, a);
               if (wr) begin
                  check_eq("wdata", bram_wr_data, wd);
                  ref_mem[a] = wd;
               end
               e.port = g0 ? 0 : 1;
               e.data = ref_mem[a];
               sb.push_back(e);
               ptr_m = g0 ? 1'b1 : 1'b0;
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drv(input logic v0, input logic w0, input int a0, input logic [DW-1:0] d0,
                      input logic v1, input logic w1, input int a1, input logic [DW-1:0] d1);
      p0_req_valid = v0; p0_req_wr = w0; p0_req_addr = AW'(a0); p0_req_wdata = d0;
      p1_req_valid = v1; p1_req_wr = w1; p1_req_addr = AW'(a1); p1_req_wdata = d1;
   endtask

   task automatic idle(input int n);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic wait_init();
      int cnt = 0;
      while (init_busy && cnt < 100) begin
         cyc();
         cnt++;
      end
      check_eq("init_len", cnt, INIT_EN ? NS : 0);
   endtask

   task automatic do_reset(input bit wait_done);
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      rst_ni = 1'b0;
      cyc();
      cyc();
      rst_ni = 1'b1;
      if (wait_done) wait_init();
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int c;
      for (int i = 0; i < NS; i++) begin
         mem[i]     = 32'hA500_0000 | DW'(i);
         ref_mem[i] = 32'hA500_0000 | DW'(i);
      end
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset(1);

      // Scenario 1: write then read back at address 5
      drv(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
      cyc();
      drv(1, 0, 5, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_eq("s1_wr_v", p0_rsp_valid, 1);
      check_eq("s1_wr_d", p0_rsp_data, 32'hDEADBEEF);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_eq("s1_rd_v", p0_rsp_valid, 1);
      check_eq("s1_rd_d", p0_rsp_data, 32'hDEADBEEF);
      idle(2);

      // Scenario 2: both ports contend for 6 cycles
      do_reset(1);
      gnt_log.delete();
      for (int i = 0; i < 6; i++) begin
         drv(1, 0, i, 0, 1, 0, 8 + i, 0);
         cyc();
      end
      idle(2);
      check_eq("s2_n", gnt_log.size(), 6);
      for (int i = 0; i < 6; i++) check_eq($sformatf("s2_g%0d", i), gnt_log[i], i % 2);

      // Scenario 3: p1 alone for 3 cycles, then contention
      do_reset(1);
      gnt_log.delete();
      for (int i = 0; i < 3; i++) begin
         drv(0, 0, 0, 0, 1, 0, i, 0);
         cyc();
      end
      for (int i = 0; i < 2; i++) begin
         drv(1, 0, 3, 0, 1, 0, 4, 0);
         cyc();
      end
      idle(2);
      check_eq("s3_n", gnt_log.size(), 5);
      check_eq("s3_g0", gnt_log[0], 1);
      check_eq("s3_g2", gnt_log[2], 1);
      check_eq("s3_g3", gnt_log[3], 0);
      check_eq("s3_g4", gnt_log[4], 1);

      // Scenario 4: reset in the cycle after a p0 grant drops its response
      do_reset(1);
      drv(0, 0, 0, 0, 1, 0, 2, 0);
      cyc();
      c = rsp0_cnt;
      gnt_log.delete();
      drv(1, 0, 5, 0, 0, 0, 0, 0);
      cyc();
      rst_ni = 1'b0;
      drv(1, 0, 5, 0, 1, 0, 6, 0);
      cyc();
      rst_ni = 1'b1;
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      wait_init();
      drv(1, 0, 7, 0, 1, 0, 9, 0);
      cyc();
      idle(2);
      check_eq("s4_n", gnt_log.size(), 2);
      check_eq("s4_ptr", gnt_log[1], 0);
      check_eq("s4_rsp0", rsp0_cnt - c, 1);

      // Scenario 5: reset part way through the sweep, then read the top address
      do_reset(0);
      idle(5);
      do_reset(1);
      drv(1, 0, 15, 0, 0, 0, 0, 0);
      cyc();
      drv(0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check_eq("s5_v", p0_rsp_valid, 1);
      check_eq("s5_d", p0_rsp_data, INIT_EN ? 32'h0 : 32'hA500_000F);
      idle(2);

      // Scenario 6: streaming reads from p0 must not bubble
      do_reset(1);
      c = rsp0_cnt;
      max_run0 = 0;
      for (int i = 0; i < 8; i++) begin
         drv(1, 0, i, 0, 0, 0, 0, 0);
         cyc();
      end
      idle(3);
      check_eq("s6_cnt", rsp0_cnt - c, 8);
      check_eq("s6_run", max_run0, 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/sp_bram_arb.md
SP_BRAM_ARB -- requirements
Module: sp_bram_arb

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 32, meaning the word width of the shared single-port BRAM.
REQ-002 The module SHALL have parameter NUM_SETS, default 1024, meaning the BRAM depth; AW = $clog2(NUM_SETS).
REQ-003 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_ni  input  1  reset; synchronous, active-low.
REQ-005 The module SHALL have ports pN_req_valid  input  1  request from requester N, for N in {0,1}.
REQ-006 The module SHALL have ports pN_req_ready  output  1  request accepted this cycle.
REQ-007 The module SHALL have ports pN_req_wr  input  1  1 = write, 0 = read.
REQ-008 The module SHALL have ports pN_req_addr  input  AW  set index, and pN_req_wdata  input  DATA_WIDTH  write data.
REQ-009 The module SHALL have ports pN_rsp_valid  output  1  response strobe, and pN_rsp_data  output  DATA_WIDTH  read data, or written data for writes.
REQ-010 The module SHALL have BRAM-side ports bram_chip_en  output  1, bram_addr  output  AW, bram_wr_en  output  1, bram_wr_data  output  DATA_WIDTH, and bram_rd_data  input  DATA_WIDTH; the BRAM is write-first with 1-cycle latency.
REQ-011 The module SHALL have port init_busy  output  1  initialisation sweep in progress.

Function
REQ-012 A request SHALL transfer when pN_req_valid and pN_req_ready are both 1 in the same cycle; at most one port SHALL be ready per cycle.
REQ-013 pN_req_ready SHALL be combinational from the valids and the round-robin pointer; it SHALL be 0 while init_busy is 1.
REQ-014 Only one valid: that port SHALL be granted regardless of the pointer.
REQ-015 Both valid: the port named by the pointer SHALL be granted.
REQ-016 After any grant, the pointer SHALL point to the non-granted port.
REQ-017 On a grant, the module SHALL drive bram_chip_en=1 and bram_wr_en=pN_req_wr, and pass pN_req_addr/pN_req_wdata combinationally in the same cycle.
REQ-018 In cycles with no grant and no init write, bram_chip_en SHALL be 0.
REQ-019 The granted port's rsp_valid SHALL be 1 exactly one cycle after the grant, with rsp_data = bram_rd_data; the other port's rsp_valid SHALL be 0.
REQ-020 Responses SHALL NOT be back-pressured; back-to-back grants SHALL yield back-to-back responses, giving full throughput of 1 access per cycle.
REQ-021 pN_rsp_data SHALL be don't-care when pN_rsp_valid is 0.

Reset
REQ-022 While rst_ni=0 at a clock edge: the pointer SHALL reset to port 0, the pending response SHALL be cleared, and both rsp_valid outputs SHALL be 0 after that edge.
REQ-023 A reset asserted in the cycle after a grant SHALL drop that grant's response; no rsp_valid SHALL appear.
REQ-024 While rst_ni=0, pN_req_ready and bram_chip_en SHALL be 0.

Configuration
REQ-025 With macro SP_BRAM_ARB_INIT_EN defined, after reset release the FSM SHALL enter INIT and write 0 to addresses 0..NUM_SETS-1 in ascending order, one per cycle, with init_busy=1; it SHALL then move to RUN.
REQ-026 INIT writes SHALL NOT produce any rsp_valid.
REQ-027 When INIT completes, the first grant SHALL be possible in cycle NUM_SETS after reset release.
REQ-028 A reset during INIT SHALL restart the sweep at address 0.
REQ-029 Without SP_BRAM_ARB_INIT_EN, the FSM SHALL enter RUN directly, init_busy SHALL be tied to 0, and a grant SHALL be possible in the first cycle after reset release.

Verification
REQ-030 Scenario 1: p0 writes 0xDEADBEEF to address 5, then p0 reads address 5 -> p0_rsp_valid is 1 one cycle after each grant, and both responses carry 0xDEADBEEF.
REQ-031 Scenario 2: p0 and p1 both hold valid reads for 6 cycles after reset -> grants are p0,p1,p0,p1,p0,p1 and the responses are routed to the matching ports.
REQ-032 Scenario 3: only p1 is valid for 3 cycles, then both are valid -> p1 is granted 3 times, then p0 is granted first.
REQ-033 Scenario 4: rst_ni is pulsed low the cycle after a p0 read grant -> no p0_rsp_valid; the pointer returns to p0.
REQ-034 Scenario 5: SP_BRAM_ARB_INIT_EN defined with NUM_SETS=16 -> init_busy is 1 for 16 cycles; a read of address 15 returns 0; no rsp_valid appears during INIT.
REQ-035 Scenario 6: p0 issues continuous reads of addresses 0..7 with p1 idle -> 8 consecutive p0_rsp_valid cycles with no bubbles.
